fm_mod_iq: RTL and testbench

//  FM modulator: TX counterpart of the FM demodulator. Accepts signed audio on AXI-Stream,

---
 rtl/fm_mod_iq_if.sv | 13 +
 rtl/fm_mod_iq.sv | 102 ++++++++++
 tb/tb_fm_mod_iq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fm_mod_iq_if.sv
// fm_mod_iq_if: AXI-Stream link carrying one 32-bit beat with tlast/tstrb
//   master: drives tvalid, tdata, tlast, tstrb; samples tready
//   slave : samples tvalid, tdata, tlast, tstrb; drives tready
interface fm_mod_iq_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tstrb;

    modport master (output tvalid, tdata, tlast, tstrb, input tready);
    modport slave  (input tvalid, tdata, tlast, tstrb, output tready);
endinterface

// File: rtl/fm_mod_iq.sv
// fm_mod_iq: FM modulator turning signed audio into complex baseband I/Q via a phase accumulator and sine LUT
//   s00_axis_aclk   : clock
//   s00_axis_areset : synchronous active-high reset
//   s00_axis        : audio in, tdata[15:0] signed sample, tlast forwarded, tstrb ignored
//   m00_axis        : I/Q out, tdata[15:0] I, tdata[31:16] Q, tlast forwarded, tstrb = 4'hF
module fm_mod_iq #(
    parameter int                        PHASE_W    = 32,
    parameter int                        LUT_AW     = 10,
    parameter logic signed [PHASE_W-1:0] CENTER_INC = '0,
    parameter logic signed [15:0]        DEV_GAIN   = 16'sd4096,
    parameter int                        DEV_SHIFT  = 0,
    parameter int                        AMP_SHIFT  = 0
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    fm_mod_iq_if.slave  s00_axis,
    fm_mod_iq_if.master m00_axis
);
    localparam int N = 1 << LUT_AW;

    // Elaboration-time sine: fold onto the first quadrant so the table is exactly
    // symmetric, then a Taylor series that is far more accurate than 16-bit rounding.
    function automatic logic signed [15:0] sin_val(input int k);
        int h, m;
        real x, t, s;
        logic signed [15:0] v;
        h = k % (N / 2);
        m = (h > N / 4) ? N / 2 - h : h;
        x = 6.283185307179586 * real'(m) / real'(N);
        t = x;
        s = x;
        for (int n = 1; n < 10; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        v = 16'($rtoi(32767.0 * s + 0.5));
        return (k >= N / 2) ? -v : v;
    endfunction

    logic signed [15:0] lut [N];

    genvar g;
    for (g = 0; g < N; g++) begin : g_lut
        localparam logic signed [15:0] V = sin_val(g);
        assign lut[g] = V;
    end

    logic               en;
    logic               s_hs;
    logic signed [31:0] prod;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [LUT_AW-1:0]  idx, idx_c;
    logic               v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;
    logic signed [15:0] i2_q, q2_q;
    logic [31:0]        data3_q;
    logic               unused_bits;

    // Whole pipeline advances together whenever the output slot is free or drains.
    always_comb begin
        en      = !v3_q || m00_axis.tready;
        s_hs    = s00_axis.tvalid && s00_axis.tready;
        prod    = 32'($signed(s00_axis.tdata[15:0])) * 32'(DEV_GAIN);
        inc     = PHASE_W'(prod >>> DEV_SHIFT) + CENTER_INC;
        phase_d = s_hs ? phase_q + inc : phase_q;
        idx     = phase_q[PHASE_W-1 -: LUT_AW];
        idx_c   = idx + LUT_AW'(N / 4);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            phase_q <= '0;
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
            v2_q    <= 1'b0;
            l2_q    <= 1'b0;
            i2_q    <= '0;
            q2_q    <= '0;
            v3_q    <= 1'b0;
            l3_q    <= 1'b0;
            data3_q <= '0;
        end else if (en) begin
            phase_q <= phase_d;
            v1_q    <= s_hs;
            l1_q    <= s_hs && s00_axis.tlast;
            v2_q    <= v1_q;
            l2_q    <= l1_q;
            q2_q    <= lut[idx] >>> AMP_SHIFT;
            i2_q    <= lut[idx_c] >>> AMP_SHIFT;
            v3_q    <= v2_q;
            l3_q    <= l2_q;
            data3_q <= v2_q ? {q2_q, i2_q} : data3_q;
        end
    end

    assign s00_axis.tready = en && !s00_axis_areset;
    assign m00_axis.tvalid = v3_q;
    assign m00_axis.tdata  = data3_q;
    assign m00_axis.tlast  = l3_q;
    assign m00_axis.tstrb  = 4'hF;
    assign unused_bits     = ^{s00_axis.tdata[31:16], s00_axis.tstrb};
endmodule

// File: tb/tb_fm_mod_iq.sv
// tb_fm_mod_iq: randomized scoreboard bench for fm_mod_iq (two carrier offsets in parallel)
module tb_fm_mod_iq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tv = 1'b0;
    logic        tl = 1'b0;
    logic [31:0] td = '0;
    logic        mr = 1'b1;
    int          mr_mode = 1;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_sent = 0;

    int unsigned ph [2];
    logic [32:0] fq [2][64];
    int          wp [2];
    int          rp [2];
    logic        hold [2];
    logic [32:0] held [2];
    int          n_out [2];

    fm_mod_iq_if s0 ();
    fm_mod_iq_if m0 ();
    fm_mod_iq_if s1 ();
    fm_mod_iq_if m1 ();

    assign s0.tvalid = tv;
    assign s0.tdata  = td;
    assign s0.tlast  = tl;
    assign s0.tstrb  = 4'hF;
    assign s1.tvalid = tv;
    assign s1.tdata  = td;
    assign s1.tlast  = tl;
    assign s1.tstrb  = 4'hF;
    assign m0.tready = mr;
    assign m1.tready = mr;

    fm_mod_iq dut0 (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis       (s0),
        .m00_axis       (m0)
    );

    fm_mod_iq #(.CENTER_INC(32'sh4000_0000)) dut1 (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis       (s1),
        .m00_axis       (m1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        mr = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : (mr_mode == 1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lut_ref(input int k);
        real s;
        int r;
        s = 32767.0 * $sin(6.283185307179586 * real'(k) / 1024.0);
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        return 16'(r);
    endfunction

    function automatic int unsigned inc_of(input logic [15:0] s, input int d);
        return 32'(int'($signed(s)) * 4096) + ((d == 1) ? 32'h4000_0000 : 32'h0);
    endfunction

    function automatic logic [31:0] iq_of(input int unsigned p);
        int k;
        k = int'(p >> 22);
        return {lut_ref(k), lut_ref((k + 256) % 1024)};
    endfunction

    task automatic mon(input int d, input logic s_rdy, input logic m_v, input logic [31:0] m_d, input logic m_l);
        logic [32:0] o;
        o = {m_l, m_d};
        if (hold[d]) chk($sformatf("stable%0d", d), o, held[d]);
        hold[d] = m_v && !mr;
        held[d] = o;
        if (tv && s_rdy) begin
            ph[d] += inc_of(td[15:0], d);
            fq[d][wp[d] % 64] = {tl, iq_of(ph[d])};
            wp[d]++;
        end
        if (m_v && mr) begin
            n_out[d]++;
            chk($sformatf("pending%0d", d), wp[d] > rp[d], 1);
            if (wp[d] > rp[d]) begin
                chk($sformatf("out%0d_%0d", d, rp[d]), o, fq[d][rp[d] % 64]);
                rp[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                ph[d] = 0;
                wp[d] = 0;
                rp[d] = 0;
                hold[d] = 1'b0;
            end
        end else begin
            mon(0, s0.tready, m0.tvalid, m0.tdata, m0.tlast);
            mon(1, s1.tready, m1.tvalid, m1.tdata, m1.tlast);
        end
    end

    task automatic send(input logic [15:0] s, input logic l);
        int t;
        t = 0;
        tv = 1'b1;
        td = {16'($urandom), s};
        tl = l;
        forever begin
            @(negedge clk);
            if (s0.tready && s1.tready) break;
            if (++t > 200) begin
                chk("send_timeout", s0.tready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        n_sent++;
        tv = 1'b0;
        tl = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (wp[0] != rp[0] || wp[1] != rp[1]); t++) idle(1);
        chk("drain0", wp[0] - rp[0], 0);
        chk("drain1", wp[1] - rp[1], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) n_out[d] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m0.tvalid, 0);
        chk("rst_tdata", m0.tdata, 0);
        chk("rst_tlast", m0.tlast, 0);
        chk("rst_tready", s0.tready, 0);
        chk("rst_tvalid1", m1.tvalid, 0);
        chk("tstrb", m0.tstrb, 4'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", s0.tready, 1);
        idle(1);
        tv = 1'b1;
        td = 32'hA5A5_0000;
        @(posedge clk);
        #1;
        tv = 1'b0;
        n_sent++;
        chk("lat_k", m0.tvalid, 0);
        idle(1);
        chk("lat_k1", m0.tvalid, 0);
        idle(1);
        chk("lat_k2", m0.tvalid, 1);
        chk("first_iq0", m0.tdata, 32'h0000_7FFF);
        chk("first_iq1", m1.tdata, 32'h7FFF_0000);
        repeat (7) send(16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'sd2048, 1'b0);
        for (int i = 0; i < 4; i++) send(-16'sd2048, 1'b0);
        for (int i = 0; i < 8; i++) send(16'($urandom), i == 4);
        drain();
        mr_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(16'($urandom), 1'($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end
        mr_mode = 1;
        drain();
        chk("count0", n_out[0], n_sent);
        chk("count1", n_out[1], n_sent);
        mr_mode = 0;
        idle(2);
        for (int i = 0; i < 3; i++) send(16'($urandom), 1'b0);
        rst = 1'b1;
        idle(1);
        chk("tready_in_rst", s0.tready, 0);
        idle(1);
        chk("flush_tvalid", m0.tvalid, 0);
        rst = 1'b0;
        mr_mode = 1;
        idle(1);
        send(16'h0000, 1'b0);
        for (int t = 0; t < 10 && !m0.tvalid; t++) idle(1);
        chk("post_rst_valid", m0.tvalid, 1);
        chk("post_rst_iq0", m0.tdata, 32'h0000_7FFF);
        chk("post_rst_iq1", m1.tdata, 32'h7FFF_0000);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
